// File: rtl/fdc_sector_server.sv
// fdc_sector_server
// Serves the floppy controller's SD-side sector requests from a byte-wide
// image memory. A read streams one 512-byte sector into the controller's
// buffer. A write drains the controller's buffer back into the image.
// Sectors that lie past the end of the image read as zeros, and writes to
// them are discarded.
//
// Ports
//   clk_sys, reset          rising-edge clock, asynchronous active-high reset
//   img_size                image size in bytes (same for both drives)
//   sd_lba, sd_rd, sd_wr    request side; sd_rd/sd_wr are per-drive levels
//   sd_ack                  high while a transfer is in progress
//   sd_buff_addr/dout/wr    controller buffer write port (read transfers)
//   sd_buff_din             controller buffer read data (write transfers)
//   mem_addr/rd/wr/wdata    image memory request
//   mem_rdata, mem_ready    image memory response
//   busy                    engine is not idle
module fdc_sector_server #(
    parameter int          ACK_DELAY   = 4,
    parameter logic [31:0] DRIVE1_BASE = 32'h0010_0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] img_size,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [7:0]  sd_buff_din,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_RD_MEM, S_RD_PUT, S_WR_ADDR, S_WR_CAP, S_WR_MEM, S_DONE
    } state_t;

    localparam logic [15:0] DELAY_LOAD = 16'(ACK_DELAY);
    localparam logic [8:0]  LAST_IDX   = 9'd511;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        oob_q, oob_d;
    logic [31:0] base_q, base_d;
    logic [31:0] off_q, off_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [7:0]  dout_q, dout_d;
    logic        bwr_q, bwr_d;
    logic [31:0] maddr_q, maddr_d;
    logic        mrd_q, mrd_d;
    logic        mwr_q, mwr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;

    logic        req_any_s;
    logic        req_drive_s;
    logic        req_wr_s;
    logic [31:0] req_off_s;
    logic        req_oob_s;
    logic [8:0]  idx_inc_s;
    logic [31:0] cur_addr_s;
    logic [31:0] next_addr_s;
    logic [8:0]  lba_unused_s;

    // Only 23 LBA bits fit in a 32-bit byte offset; the rest are ignored.
    assign lba_unused_s = sd_lba[31:23];

    // Request decode: fixed priority rd0, rd1, wr0, wr1.
    always_comb begin
        req_any_s = |{sd_rd, sd_wr};
        if (sd_rd[0]) begin
            req_drive_s = 1'b0;
            req_wr_s    = 1'b0;
        end else if (sd_rd[1]) begin
            req_drive_s = 1'b1;
            req_wr_s    = 1'b0;
        end else if (sd_wr[0]) begin
            req_drive_s = 1'b0;
            req_wr_s    = 1'b1;
        end else begin
            req_drive_s = 1'b1;
            req_wr_s    = 1'b1;
        end
    end

    // Sector offset and bounds test; 33 bits so a sector near 4 GiB cannot wrap past the limit.
    assign req_off_s   = {sd_lba[22:0], 9'd0};
    assign req_oob_s   = ({1'b0, req_off_s} + 33'd512) > {1'b0, img_size};
    assign idx_inc_s   = idx_q + 9'd1;
    assign cur_addr_s  = base_q + off_q + {23'd0, idx_q};
    assign next_addr_s = base_q + off_q + {23'd0, idx_inc_s};

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        oob_d   = oob_q;
        base_d  = base_q;
        off_d   = off_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        bwr_d   = 1'b0;
        maddr_d = maddr_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_any_s) begin
                    is_wr_d = req_wr_s;
                    base_d  = req_drive_s ? DRIVE1_BASE : 32'd0;
                    off_d   = req_off_s;
                    oob_d   = req_oob_s;
                    idx_d   = 9'd0;
                    cnt_d   = DELAY_LOAD;
                    ack_d   = 1'b1;
                    state_d = S_DELAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                if (cnt_q == 16'd0) begin
                    if (is_wr_q) begin
                        state_d = S_WR_ADDR;
                    end else begin
                        mrd_d   = ~oob_q;
                        maddr_d = cur_addr_s;
                        state_d = S_RD_MEM;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RD_MEM: begin
                // Out-of-bounds bytes never touch memory and read as zero.
                if (oob_q) begin
                    dout_d  = 8'h00;
                    bwr_d   = 1'b1;
                    state_d = S_RD_PUT;
                end else if (mem_ready) begin
                    dout_d  = mem_rdata;
                    mrd_d   = 1'b0;
                    bwr_d   = 1'b1;
                    state_d = S_RD_PUT;
                end else begin
                    state_d = S_RD_MEM;
                end
            end
            S_RD_PUT: begin
                if (idx_q == LAST_IDX) begin
                    ack_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_inc_s;
                    mrd_d   = ~oob_q;
                    maddr_d = next_addr_s;
                    state_d = S_RD_MEM;
                end
            end
            S_WR_ADDR: begin
                // The buffer needs one cycle after the address change before din is valid.
                state_d = S_WR_CAP;
            end
            S_WR_CAP: begin
                wdata_d = sd_buff_din;
                mwr_d   = ~oob_q;
                maddr_d = cur_addr_s;
                state_d = S_WR_MEM;
            end
            S_WR_MEM: begin
                if (oob_q || mem_ready) begin
                    mwr_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        ack_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc_s;
                        state_d = S_WR_ADDR;
                    end
                end else begin
                    state_d = S_WR_MEM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output storage.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            oob_q   <= 1'b0;
            base_q  <= 32'd0;
            off_q   <= 32'd0;
            idx_q   <= 9'd0;
            cnt_q   <= 16'd0;
            ack_q   <= 1'b0;
            dout_q  <= 8'h00;
            bwr_q   <= 1'b0;
            maddr_q <= 32'd0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            oob_q   <= oob_d;
            base_q  <= base_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            bwr_q   <= bwr_d;
            maddr_q <= maddr_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = bwr_q;
    assign mem_addr     = maddr_q;
    assign mem_rd       = mrd_q;
    assign mem_wr       = mwr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = busy_q;

endmodule
